dds_nco_multi: RTL and testbench

DDS_NCO_MULTI -- requirements
Module: dds_nco_multi

---
 rtl/dds_nco_multi.sv | 171 +++++++++++++++++
 tb/tb_dds_nco_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_nco_multi.sv
// dds_nco_multi: N_CH independent numerically controlled oscillators sharing
// one fixed sine table.
//
// Each channel runs a phase accumulator (acc += pinc). A registered phase
// (ph = acc + poff) feeds a registered table lookup. The table lookup is one
// cycle behind the phase.
//
// Configuration uses two register levels per channel:
//   - a write goes into the channel's shadow pinc/poff;
//   - an apply copies every shadow register into the active registers at once.
// This keeps multi-channel retunes phase-coherent.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   i_cfg_valid    one-cycle strobe, writes i_pinc/i_poff into shadow of i_cfg_ch
//   i_cfg_ch       target channel of the write (out-of-range writes are dropped)
//   i_pinc         phase increment, unsigned
//   i_poff         phase offset, unsigned
//   i_cfg_apply    one-cycle strobe, shadow -> active for all channels
//   i_phase_clr    qualified by i_cfg_apply, zeroes every accumulator
//   o_phase        per-channel phase, channel k at [k*PHASE_W +: PHASE_W]
//   o_data         per-channel signed sine sample, channel k at [k*OUT_W +: OUT_W]
//   o_valid        pipeline holds valid samples
//   o_cfg_pending  shadow writes exist that have not been applied
module dds_nco_multi #(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 16,
  parameter int LUT_AW  = 10,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_cfg_valid,
  input  logic [CH_W-1:0]           i_cfg_ch,
  input  logic [PHASE_W-1:0]        i_pinc,
  input  logic [PHASE_W-1:0]        i_poff,
  input  logic                      i_cfg_apply,
  input  logic                      i_phase_clr,
  output logic [N_CH*PHASE_W-1:0]   o_phase,
  output logic [N_CH*OUT_W-1:0]     o_data,
  output logic                      o_valid,
  output logic                      o_cfg_pending
);

  localparam int  LUT_N = 1 << LUT_AW;
  localparam real PI    = 3.14159265358979323846;

  // Table entry k = round(A * sin(2*pi*k/LUT_N)) with A = 2^(OUT_W-1)-1.
  // Evaluated at elaboration only. The angle is folded into the first
  // quadrant so the Taylor series stays well inside its accurate range.
  // That also makes the quarter-wave points exact.
  function automatic logic signed [OUT_W-1:0] sine_entry(input int k);
    int  half;
    int  quarter;
    int  m;
    int  mag;
    logic neg;
    real a;
    real term;
    real sum;
    real amp;
    half    = LUT_N / 2;
    quarter = LUT_N / 4;
    neg     = (k >= half);
    m       = neg ? (k - half) : k;
    if (m > quarter) m = half - m;
    a    = 2.0 * PI * real'(m) / real'(LUT_N);
    term = a;
    sum  = a;
    for (int n = 1; n <= 14; n++) begin
      term = -term * a * a / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((64'd1 << (OUT_W - 1)) - 64'd1);
    mag = $rtoi(amp * sum + 0.5);
    if (neg) mag = -mag;
    return mag[OUT_W-1:0];
  endfunction

  logic signed [OUT_W-1:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic signed [OUT_W-1:0] VAL = sine_entry(k);
    assign lut[k] = VAL;
  end

  logic [PHASE_W-1:0]      sh_pinc  [N_CH];
  logic [PHASE_W-1:0]      sh_poff  [N_CH];
  logic [PHASE_W-1:0]      act_pinc [N_CH];
  logic [PHASE_W-1:0]      act_poff [N_CH];
  logic [PHASE_W-1:0]      acc      [N_CH];
  logic [PHASE_W-1:0]      ph       [N_CH];
  logic signed [OUT_W-1:0] dat      [N_CH];
  logic [N_CH-1:0]         wr_sel;
  logic                    wr_ok;
  logic                    valid_d;

  // Decode to a one-hot write select. A channel number >= N_CH matches no
  // bit, so that write is dropped without a separate range check.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      wr_sel[k] = i_cfg_valid && (32'(i_cfg_ch) == 32'(k));
    end
  end

  assign wr_ok = |wr_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        sh_pinc[k]  <= '0;
        sh_poff[k]  <= '0;
        act_pinc[k] <= '0;
        act_poff[k] <= '0;
        acc[k]      <= '0;
        ph[k]       <= '0;
        dat[k]      <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_sel[k]) begin
          sh_pinc[k] <= i_pinc;
          sh_poff[k] <= i_poff;
        end
        // A write landing in the same cycle as the apply goes straight to
        // the active registers.
        if (i_cfg_apply) begin
          act_pinc[k] <= wr_sel[k] ? i_pinc : sh_pinc[k];
          act_poff[k] <= wr_sel[k] ? i_poff : sh_poff[k];
        end
        // The accumulator still uses the old active pinc on the apply edge.
        if (i_cfg_apply && i_phase_clr) acc[k] <= '0;
        else                            acc[k] <= acc[k] + act_pinc[k];
        ph[k]  <= acc[k] + act_poff[k];
        dat[k] <= lut[ph[k][PHASE_W-1 -: LUT_AW]];
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign o_phase[k*PHASE_W +: PHASE_W] = ph[k];
    assign o_data[k*OUT_W +: OUT_W]      = dat[k];
  end

  // Apply wins over a simultaneous write, because that write was already
  // carried into the active registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cfg_pending <= 1'b0;
    end else if (i_cfg_apply) begin
      o_cfg_pending <= 1'b0;
    end else if (wr_ok) begin
      o_cfg_pending <= 1'b1;
    end
  end

  // Two-stage fill flag matching the acc -> ph -> data pipeline depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      valid_d <= 1'b1;
      o_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_dds_nco_multi.sv
module tb_dds_nco_multi;

  localparam int PW = 16;
  localparam int OW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic [0:0]      cfg_ch = 1'b0;
  logic [PW-1:0]   pinc = '0;
  logic [PW-1:0]   poff = '0;
  logic            apply = 1'b0;
  logic            clr = 1'b0;
  logic [2*PW-1:0] phase;
  logic [2*OW-1:0] data;
  logic            valid;
  logic            pend;

  logic            cfg_valid3 = 1'b0;
  logic [1:0]      cfg_ch3 = 2'd0;
  logic [3*PW-1:0] phase3;
  logic [3*OW-1:0] data3;
  logic            valid3;
  logic            pend3;

  dds_nco_multi #(.N_CH(2), .PHASE_W(PW), .OUT_W(OW), .LUT_AW(10)) dut (
    .clk(clk), .rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_ch(cfg_ch),
    .i_pinc(pinc), .i_poff(poff), .i_cfg_apply(apply), .i_phase_clr(clr),
    .o_phase(phase), .o_data(data), .o_valid(valid), .o_cfg_pending(pend)
  );

  // Three-channel copy so that an out-of-range channel number is expressible.
  dds_nco_multi #(.N_CH(3), .PHASE_W(PW), .OUT_W(OW), .LUT_AW(10)) dut3 (
    .clk(clk), .rst(rst), .i_cfg_valid(cfg_valid3), .i_cfg_ch(cfg_ch3),
    .i_pinc(pinc), .i_poff(poff), .i_cfg_apply(apply), .i_phase_clr(clr),
    .o_phase(phase3), .o_data(data3), .o_valid(valid3), .o_cfg_pending(pend3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sel;
    int          ch;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  function automatic logic [31:0] observe(input int sel, input int ch);
    case (sel)
      0: return {16'h0, phase[ch*PW +: PW]};
      1: return 32'(signed'(data[ch*OW +: OW]));
      2: return {31'b0, valid};
      3: return {31'b0, pend};
      4: return {31'b0, pend3};
      5: return {16'h0, phase3[ch*PW +: PW]};
      6: return {31'b0, valid3};
      7: return 32'(signed'(data3[ch*OW +: OW]));
      default: return '1;
    endcase
  endfunction

  // Expected sample for a 16-bit phase, straight from the sine definition.
  function automatic int lut_ref(input int ph);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'((ph & 'hFFFF) >> 6) / 1024.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  task automatic expect_at(input int dly, input int sel, input int ch,
                           input logic [31:0] v, input string tag);
    exp_t e;
    e.at  = cyc + dly;
    e.sel = sel;
    e.ch  = ch;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: after every edge, retire the expectations due on that edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          cmp(sb[i].tag, observe(sb[i].sel, sb[i].ch), sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int ca;
    int cb;
    int c;
    int dq[6];
    dq = '{0, 32767, 0, -32767, 0, 32767};

    // reset state
    tick();
    tick();
    expect_at(1, 2, 0, 0, "rst_valid");
    expect_at(1, 3, 0, 0, "rst_pend");
    expect_at(1, 0, 0, 0, "rst_ph0");
    expect_at(1, 1, 1, 0, "rst_data1");
    tick();
    rst = 1'b0;
    expect_at(1, 2, 0, 0, "valid_edge1");
    expect_at(2, 2, 0, 1, "valid_edge2");
    expect_at(2, 6, 0, 1, "valid3_edge2");
    tick();
    tick();

    // quarter-rate tone on ch0, applied with phase clear
    cfg_valid = 1'b1; cfg_ch = 1'b0; pinc = 16'h4000; poff = 16'h0000;
    expect_at(1, 3, 0, 1, "pend_after_wr");
    expect_at(1, 0, 0, 0, "ph0_shadow_only");
    tick();
    cfg_valid = 1'b0; apply = 1'b1; clr = 1'b1;
    ca = cyc + 1;
    expect_at(1, 3, 0, 0, "pend_after_apply");
    expect_at(1, 2, 0, 1, "valid_thru_apply");
    for (int j = 1; j <= 6; j++)
      expect_at(1 + j, 0, 0, 32'(((j - 1) * 'h4000) & 'hFFFF), "ph0_quarter");
    for (int j = 2; j <= 7; j++)
      expect_at(1 + j, 1, 0, 32'(dq[j-2]), "d0_quarter");
    expect_at(3, 0, 1, 0, "ph1_idle");
    tick();
    apply = 1'b0; clr = 1'b0;
    repeat (8) tick();

    // shadow-only write on ch1 held for 20 cycles, then applied
    cfg_valid = 1'b1; cfg_ch = 1'b1; pinc = 16'h1000; poff = 16'h0000;
    expect_at(1, 3, 0, 1, "pend_hold_1");
    expect_at(20, 3, 0, 1, "pend_hold_20");
    expect_at(1, 0, 1, 0, "ph1_hold_1");
    expect_at(10, 0, 1, 0, "ph1_hold_10");
    expect_at(20, 0, 1, 0, "ph1_hold_20");
    expect_at(20, 1, 1, 0, "d1_hold_20");
    tick();
    cfg_valid = 1'b0;
    repeat (19) tick();
    apply = 1'b1;
    expect_at(1, 3, 0, 0, "pend_clear_apply");
    for (int j = 2; j <= 6; j++)
      expect_at(j, 0, 1, 32'((j - 2) * 'h1000), "ph1_step");
    for (int j = 3; j <= 7; j++)
      expect_at(j, 1, 1, 32'(lut_ref((j - 3) * 'h1000)), "d1_step");
    expect_at(3, 0, 0, 32'(((cyc + 3 - ca - 1) * 'h4000) & 'hFFFF), "ph0_unaffected");
    tick();
    apply = 1'b0;
    repeat (7) tick();

    // write-through: poff written and applied in the same cycle
    cfg_valid = 1'b1; cfg_ch = 1'b0; pinc = 16'h4000; poff = 16'h4000; apply = 1'b1;
    c = cyc;
    expect_at(1, 3, 0, 0, "pend_wt_1");
    expect_at(2, 3, 0, 0, "pend_wt_2");
    for (int e = c + 2; e <= c + 5; e++)
      expect_at(e - c, 0, 0, 32'(((e - ca) * 'h4000) & 'hFFFF), "ph0_offset");
    expect_at(3, 1, 0, 32'(lut_ref((c + 2 - ca) * 'h4000)), "d0_offset");
    tick();
    cfg_valid = 1'b0; apply = 1'b0;
    repeat (6) tick();

    // pinc = 0xFFFF counts the phase down through the wrap; clear hits all channels
    cfg_valid = 1'b1; cfg_ch = 1'b0; pinc = 16'hFFFF; poff = 16'h0000;
    expect_at(1, 3, 0, 1, "pend_wrap_wr");
    tick();
    cfg_valid = 1'b0; apply = 1'b1; clr = 1'b1;
    cb = cyc + 1;
    for (int j = 1; j <= 6; j++)
      expect_at(1 + j, 0, 0, 32'(('h10000 - (j - 1)) & 'hFFFF), "ph0_wrap");
    for (int j = 1; j <= 4; j++)
      expect_at(1 + j, 0, 1, 32'((j - 1) * 'h1000), "ph1_after_clr");
    expect_at(4, 1, 0, 32'(-201), "d0_wrap");
    tick();
    apply = 1'b0; clr = 1'b0;
    repeat (3) tick();

    // phase clear without apply does nothing
    clr = 1'b1;
    c = cyc;
    expect_at(1, 3, 0, 0, "pend_clr_only");
    for (int e = c + 2; e <= c + 3; e++)
      expect_at(e - c, 0, 0, 32'(('h10000 - (e - cb - 1)) & 'hFFFF), "ph0_clr_only");
    tick();
    clr = 1'b0;
    repeat (3) tick();

    // out-of-range channel on the three-channel instance
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; pinc = 16'h1234;
    expect_at(1, 4, 0, 0, "pend3_ignored_1");
    expect_at(2, 4, 0, 0, "pend3_ignored_2");
    tick();
    cfg_valid3 = 1'b0;
    tick();
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd2;
    expect_at(1, 4, 0, 1, "pend3_accept");
    expect_at(1, 5, 2, 0, "ph3_ch2_idle");
    expect_at(1, 7, 2, 0, "d3_ch2_idle");
    tick();
    cfg_valid3 = 1'b0;
    tick();

    // asynchronous reset between edges with a write outstanding
    cfg_valid = 1'b1; cfg_ch = 1'b1; pinc = 16'h2000; poff = 16'h0000;
    expect_at(1, 3, 0, 1, "pend_before_rst");
    tick();
    cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    cmp("async_valid", observe(2, 0), 0);
    cmp("async_pend", observe(3, 0), 0);
    cmp("async_ph0", observe(0, 0), 0);
    cmp("async_ph1", observe(0, 1), 0);
    cmp("async_d0", observe(1, 0), 0);
    cmp("async_d1", observe(1, 1), 0);
    expect_at(1, 0, 0, 0, "ph0_in_rst");
    tick();
    tick();
    rst = 1'b0;
    expect_at(1, 2, 0, 0, "valid_rel_edge1");
    expect_at(2, 2, 0, 1, "valid_rel_edge2");
    expect_at(1, 3, 0, 0, "pend_rel");
    expect_at(3, 0, 0, 0, "ph0_rel");
    expect_at(4, 1, 0, 0, "d0_rel");
    tick();
    tick();
    apply = 1'b1;
    expect_at(3, 0, 1, 0, "ph1_aborted_wr");
    expect_at(3, 0, 0, 0, "ph0_unconfigured");
    tick();
    apply = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    cmp("sb_drain", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
